// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU and its consumer: stores {y, is_zero} pairs in push order
// and keeps a saturating tally of accepted zero results.
module alu_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_y,
  input  logic                       in_is_zero,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_y,
  output logic                       out_is_zero,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 zero_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready and out_valid depend only on registered count, never on the other side.
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     zero_count_q, zero_count_d;
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] head;
  logic           push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    zero_count_d = zero_count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (in_is_zero && zero_count_q != 8'hff) begin
        zero_count_d = zero_count_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      zero_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      zero_count_q <= zero_count_d;
    end
  end

  // Storage is not reset; out_valid gating below keeps stale contents hidden.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_y, in_is_zero};
    end
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_y       = out_valid ? head[WIDTH:1] : '0;
    out_is_zero = out_valid ? head[0] : 1'b0;
  end

  assign count      = count_q;
  assign zero_count = zero_count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: drivers record expected entries in a queue and an
// independent monitor pops and compares them whenever the FIFO delivers its head.
module tb_alu_result_fifo;
  localparam int W = 10;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_y = '0;
  logic           in_is_zero = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_y;
  logic           out_is_zero;
  logic           out_ready = 1'b0;
  logic [$clog2(D):0] count;
  logic [7:0]     zero_count;

  logic [W:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_pops = 0;
  int exp_zc = 0;

  alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_y(in_y), .in_is_zero(in_is_zero),
    .in_ready(in_ready), .out_valid(out_valid), .out_y(out_y), .out_is_zero(out_is_zero),
    .out_ready(out_ready), .count(count), .zero_count(zero_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns at the following falling edge with the push recorded.
  task automatic cycle_p(input logic iv, input logic [W-1:0] y, input logic z,
                         input logic ordy, output logic pushed);
    @(posedge clk); #1;
    in_valid = iv; in_y = y; in_is_zero = z; out_ready = ordy;
    @(negedge clk);
    pushed = iv && in_ready && rst_n;
    if (pushed) begin
      exp_q.push_back({y, z});
      if (z && exp_zc != 255) exp_zc++;
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] y, input logic z, input logic ordy);
    logic p;
    cycle_p(iv, y, z, ordy, p);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_y = 10'd77; in_is_zero = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_zc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compares the head against the oldest expected entry on every pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid) begin
        check("idle_out_y_zero", int'({out_y, out_is_zero}), 0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", int'({out_y, out_is_zero}), -1);
        end else begin
          check("head_entry", int'({out_y, out_is_zero}), int'(exp_q.pop_front()));
          n_pops++;
        end
      end
    end
  end

  initial begin
    logic pushed;
    int i;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_zero_count", int'(zero_count), 0);

    // Single entry: visible one edge after the push, never in the push cycle.
    cycle(1'b1, 10'd5, 1'b0, 1'b0);
    check("no_bypass_valid", int'(out_valid), 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("one_valid", int'(out_valid), 1);
    check("one_y", int'(out_y), 5);
    check("one_count", int'(count), 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("drain_count", int'(count), 0);

    // Fill to full, offer a 5th entry (also alongside a pop), then drain in order.
    for (int k = 1; k <= 4; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
    cycle(1'b1, 10'd9, 1'b0, 1'b0);
    check("full_count", int'(count), 4);
    check("full_in_ready", int'(in_ready), 0);
    cycle(1'b1, 10'd99, 1'b0, 1'b1);
    check("full_push_ignored", int'(count), 4);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("emptied_count", int'(count), 0);
    check("emptied_pops", n_pops, 5);
    cycle(1'b0, '0, 1'b0, 0);
    check("empty_pop_ignored", int'(count), 0);

    // Streaming at count=2 with simultaneous push/pop wraps both pointers.
    cycle(1'b1, 10'd10, 1'b0, 1'b0);
    cycle(1'b1, 10'd11, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, W'(12 + k), 1'b0, 1'b1);
      check("stream_count", int'(count), 2);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stream_end_count", int'(count), 2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stream_drained", int'(count), 0);

    // Reset mid-operation with count=3 and zero_count=7.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, W'(k), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, W'(40 + k), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("pre_rst_count", int'(count), 3);
    check("pre_rst_zc", int'(zero_count), 7);
    do_reset();
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_zc", int'(zero_count), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_y", int'(out_y), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);

    // 300 zero results while draining: zero_count saturates.
    i = 0;
    while (i < 300) begin
      cycle_p(1'b1, W'(i), 1'b1, 1'b1, pushed);
      if (pushed) i++;
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    check("zc_saturated", int'(zero_count), 255);
    check("zc_model", exp_zc, 255);
    check("zc_drained", int'(count), 0);

    // 1023 ALU vectors (a=i, b=1023-i, add) under random backpressure.
    n_pops = 0;
    i = 0;
    while (i < 1023) begin
      logic [W-1:0] a, b, y;
      a = W'(i);
      b = W'(1023 - i);
      y = a + b;
      cycle_p(1'b1, y, (y == '0), 1'($urandom_range(0, 1)), pushed);
      if (pushed) i++;
    end
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    check("alu_drain_queue", exp_q.size(), 0);
    check("alu_pop_total", n_pops, 1023);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("alu_final_count", int'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, the result data width, matching the ALU y output.
REQ-002 The module SHALL have parameter DEPTH, default 4, the number of FIFO entries; a power of two, at least 2.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  the upstream ALU result is valid this cycle.
REQ-006 The module SHALL have port in_y  input  WIDTH  the ALU result y.
REQ-007 The module SHALL have port in_is_zero  input  1  the ALU is_zero flag for in_y.
REQ-008 The module SHALL have port in_ready  output  1  the FIFO can accept an entry this cycle.
REQ-009 The module SHALL have port out_valid  output  1  the head entry is valid.
REQ-010 The module SHALL have port out_y  output  WIDTH  head entry result.
REQ-011 The module SHALL have port out_is_zero  output  1  head entry zero flag.
REQ-012 The module SHALL have port out_ready  input  1  the downstream consumer accepts the head entry.
REQ-013 The module SHALL have port count  output  $clog2(DEPTH)+1  the number of stored entries, 0..DEPTH.
REQ-014 The module SHALL have port zero_count  output  8  the number of accepted entries with is_zero=1, saturating.

Function
REQ-015 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; {in_y, in_is_zero} is written at the write pointer.
REQ-016 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; the read pointer advances.
REQ-017 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_y and out_is_zero SHALL present the head entry combinationally from storage.
REQ-019 out_y and out_is_zero SHALL be 0 whenever out_valid=0.
REQ-020 Latency SHALL be one cycle: an entry pushed at edge N is visible at the outputs after edge N; there is no same-cycle bypass when empty.
REQ-021 When neither a push nor a pop occurs, count SHALL hold; a push alone adds 1; a pop alone subtracts 1.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; this is possible only when 0<count<DEPTH.
REQ-023 When full (count=DEPTH), in_valid SHALL be ignored even if a pop occurs in the same cycle; the upstream holds its data.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Entries SHALL be delivered strictly in push order, with no loss or duplication.
REQ-026 zero_count SHALL increment by 1 on each push with in_is_zero=1, independent of pops, and saturate at 255.
REQ-027 Assertions of out_ready while empty and of in_valid while full SHALL have no effect on state.

Reset
REQ-028 On a rising edge with rst_n=0, pointers, count and zero_count SHALL clear to 0; out_valid SHALL be 0 and in_ready SHALL be 1 from the next cycle.
REQ-029 A reset mid-operation SHALL discard all stored entries; any push or pop in the reset cycle SHALL be ignored.
REQ-030 Storage contents SHALL NOT require reset; stale data SHALL never be visible because of REQ-019.

Verification
REQ-031 Push y=5, is_zero=0 into an empty FIFO with out_ready=0 -> after 1 edge: out_valid=1, out_y=5, count=1.
REQ-032 Push 4 entries (1,2,3,4) with out_ready=0 -> count=4 and in_ready=0; a 5th in_valid is ignored; then out_ready=1 for 4 cycles -> outputs 1,2,3,4 in order and count=0.
REQ-033 At count=2, hold in_valid=1 and out_ready=1 for 10 cycles with an incrementing y -> count stays 2, pointers wrap, and the output order is preserved.
REQ-034 Push 300 entries with in_is_zero=1 while draining continuously -> zero_count saturates at 255.
REQ-035 With count=3 and zero_count=7, assert rst_n=0 for 1 edge -> count=0, zero_count=0, out_valid=0, out_y=0, in_ready=1.
REQ-036 Feed the 1023 ALU vectors (a=i, b=1023-i, mode 2, y=1023) with random out_ready -> every y emerges exactly once and in order.
